// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU command driver.
// Contents: FSM state type, command-word field positions, widths,
// default signature polynomial/seed and a command packing helper.
package alu_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CMD_W   = 8;
  localparam int SIG_W   = 16;
  localparam int SEL_LSB = 5;
  localparam int A_LSB   = 2;
  localparam int B_LSB   = 0;

  localparam logic [SIG_W-1:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] DEF_SIG_SEED = 16'hFFFF;

  // Command word layout: [7:5]=sel, [4:2]=A, [1:0]=B
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [2:0] sel,
                                                input logic [2:0] a,
                                                input logic [1:0] b);
    logic [CMD_W-1:0] w;
    w = '0;
    w[SEL_LSB +: 3] = sel;
    w[A_LSB   +: 3] = a;
    w[B_LSB   +: 2] = b;
    return w;
  endfunction

endpackage

// File: rtl/alu_drv_misr.sv
// Signature register for the ALU command driver.
// Folds each captured result byte into a 16-bit signature:
//   sig <= ((sig << 1) ^ (sig[15] ? POLY : 0)) ^ {8'h00, data}
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset (signature -> SEED)
//   clear   - reload SEED (new run accepted)
//   capture - fold data into the signature
//   data    - result byte being captured
//   sig     - current signature
module alu_drv_misr
  import alu_drv_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0] SEED = DEF_SIG_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic [7:0]       data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_reg;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    sig_next = sig_reg;
    if (clear) begin
      sig_next = SEED;
    end else if (capture) begin
      sig_next = ({sig_reg[SIG_W-2:0], 1'b0} ^ (sig_reg[SIG_W-1] ? POLY : '0))
                 ^ {{(SIG_W-8){1'b0}}, data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_reg <= SEED;
    else     sig_reg <= sig_next;
  end

  assign sig = sig_reg;

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the packed ALU command interface.
// Drives an 8-bit command word {sel,A,B} to the ALU wrapper, waits
// SETTLE_CYCLES, samples the result byte and folds it into a signature.
// Single-op mode or a sweep of all 256 codes back-to-back.
// Optional feature macro: ALU_DRV_MISR_EN (signature register present;
// when undefined the signature output is constant zero).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start, sweep      - run request (sampled in IDLE), mode latched with it
//   cmd_sel/a/b       - single-mode command fields
//   alu_cmd           - command word to ALU wrapper
//   alu_result        - result byte from ALU wrapper
//   res_valid/data    - one-cycle pulse with captured result
//   busy, done        - run in progress / completion pulse
//   signature         - running signature
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int unsigned       SETTLE_CYCLES = 2,
  parameter logic [SIG_W-1:0]  SIG_POLY      = DEF_SIG_POLY,
  parameter logic [SIG_W-1:0]  SIG_SEED      = DEF_SIG_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sweep,
  input  logic [2:0]       cmd_sel,
  input  logic [2:0]       cmd_a,
  input  logic [1:0]       cmd_b,
  output logic [CMD_W-1:0] alu_cmd,
  input  logic [CMD_W-1:0] alu_result,
  output logic             res_valid,
  output logic [CMD_W-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [7:0]       idx_reg, idx_next;
  logic             sweep_reg, sweep_next;
  logic [CMD_W-1:0] alu_cmd_reg, alu_cmd_next;
  logic [CMD_W-1:0] res_data_reg, res_data_next;
  logic             res_valid_reg, res_valid_next;
  logic             capture;

  // Result is sampled on the edge at which the counter already holds SETTLE_CYCLES
  assign capture = (state_reg == SETTLE) && (cnt_reg == SETTLE_LAST);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    sweep_next     = sweep_reg;
    alu_cmd_next   = alu_cmd_reg;
    res_data_next  = res_data_reg;
    res_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          sweep_next   = sweep;
          alu_cmd_next = sweep ? '0 : pack_cmd(cmd_sel, cmd_a, cmd_b);
          cnt_next     = '0;
          idx_next     = '0;
          state_next   = SETTLE;
        end
      end
      SETTLE: begin
        if (capture) begin
          res_data_next  = alu_result;
          res_valid_next = 1'b1;
          if (sweep_reg && (idx_reg != 8'hFF)) begin
            // Next code goes out on the capture edge so ops run back-to-back
            idx_next     = idx_reg + 8'd1;
            alu_cmd_next = idx_reg + 8'd1;
            cnt_next     = '0;
          end else begin
            state_next = DONE;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      sweep_reg     <= 1'b0;
      alu_cmd_reg   <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      sweep_reg     <= sweep_next;
      alu_cmd_reg   <= alu_cmd_next;
      res_data_reg  <= res_data_next;
      res_valid_reg <= res_valid_next;
    end
  end

  assign alu_cmd   = alu_cmd_reg;
  assign res_data  = res_data_reg;
  assign res_valid = res_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

`ifdef ALU_DRV_MISR_EN
  alu_drv_misr #(
    .POLY (SIG_POLY),
    .SEED (SIG_SEED)
  ) u_misr (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state_reg == IDLE) && start),
    .capture (capture),
    .data    (alu_result),
    .sig     (signature)
  );
`else
  // Masking keeps the signature parameters referenced in this build
  assign signature = {SIG_W{1'b0}} & (SIG_POLY | SIG_SEED);
`endif

endmodule
